platform_scan_detector: RTL

Sequential, parametrised collision scanner for the game-physics path: on a `start` pulse it snapshots the player and a packed array of `N_OBJ` platforms, evaluates one platform per clock, and reports whether the falling player lands on any of them. It also reports the landing floor, the platform index and the number of platforms hit. It sits between the platform generator and the player-motion FSM, replacing the fixed 10-platform combinational detector. It adds configurable depth, a per-platform valid mask, horizontal wrap and a selectable floor-priority mode.

---
 rtl/platform_scan_detector_if.sv | 40 ++++
 rtl/platform_scan_detector.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/platform_scan_detector_if.sv
// Bus between the platform generator / motion FSM and platform_scan_detector.
// Ports: start, player geometry, speed, fly, packed platform arrays and valid mask (inputs to the scanner).
//        busy, done, hit, floor, hit_idx, hit_count (results from the scanner).
interface platform_scan_detector_if #(
  parameter int N_OBJ   = 10,
  parameter int COORD_W = 10,
  parameter int SPD_W   = 4,
  parameter int IDX_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
);
  logic                       start;
  logic [COORD_W-1:0]         plyr_x;
  logic [COORD_W-1:0]         plyr_y;
  logic [COORD_W-1:0]         plyr_width;
  logic [COORD_W-1:0]         plyr_height;
  logic [COORD_W-1:0]         obj_width;
  logic [COORD_W-1:0]         map_width;
  logic [SPD_W-1:0]           spd_y;
  logic                       fly;
  logic [N_OBJ*COORD_W-1:0]   obj_xs;
  logic [N_OBJ*COORD_W-1:0]   obj_ys;
  logic [N_OBJ-1:0]           obj_valid;
  logic                       busy;
  logic                       done;
  logic                       hit;
  logic [COORD_W-1:0]         floor;
  logic [IDX_W-1:0]           hit_idx;
  logic [IDX_W:0]             hit_count;

  modport master (
    output start, plyr_x, plyr_y, plyr_width, plyr_height, obj_width, map_width,
           spd_y, fly, obj_xs, obj_ys, obj_valid,
    input  busy, done, hit, floor, hit_idx, hit_count
  );

  modport slave (
    input  start, plyr_x, plyr_y, plyr_width, plyr_height, obj_width, map_width,
           spd_y, fly, obj_xs, obj_ys, obj_valid,
    output busy, done, hit, floor, hit_idx, hit_count
  );
endinterface

// File: rtl/platform_scan_detector.sv
// Sequential landing scanner: snapshots player + N_OBJ platforms on start, tests one platform per clock.
// Latency: done pulses N_OBJ cycles after the accepted start; results hold until the next done.
// Backpressure: start is only taken while idle (busy=0); a start during the done cycle is accepted.
// Ports: clk, rst_n (async active-low), bus (slave side of platform_scan_detector_if).
module platform_scan_detector #(
  parameter int N_OBJ   = 10,
  parameter int COORD_W = 10,
  parameter int SPD_W   = 4,
  parameter int NEAREST = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  platform_scan_detector_if.slave bus
);
  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  // Two extra bits: one for sums of two coordinates, one for the sign of the wrapped player x.
  localparam int W = COORD_W + 2;

  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q, state_d;

  logic [COORD_W-1:0]       px_q, px_d, py_q, py_d, pw_q, pw_d, ph_q, ph_d;
  logic [COORD_W-1:0]       ow_q, ow_d, mw_q, mw_d;
  logic [SPD_W-1:0]         spd_q, spd_d;
  logic                     fly_q, fly_d;
  logic [N_OBJ*COORD_W-1:0] xs_q, xs_d, ys_q, ys_d;
  logic [N_OBJ-1:0]         vld_q, vld_d;
  logic [IDX_W-1:0]         idx_q, idx_d;

  logic                     best_vld_q, best_vld_d;
  logic [COORD_W-1:0]       best_y_q, best_y_d;
  logic [IDX_W-1:0]         best_idx_q, best_idx_d;
  logic [IDX_W:0]           cnt_q, cnt_d;

  logic                     done_q, done_d, hit_q, hit_d;
  logic [COORD_W-1:0]       floor_q, floor_d;
  logic [IDX_W-1:0]         hit_idx_q, hit_idx_d;
  logic [IDX_W:0]           hit_count_q, hit_count_d;

  // Evaluation of the platform addressed by idx_q
  logic [COORD_W-1:0]  ox, oy;
  logic                ov;
  logic signed [W-1:0] p_l, p_r, o_l, o_r, w_l, w_r, mw_s;
  logic [W-1:0]        feet, feet_max, oy_w;
  logic                h_direct, h_wrap, v_ok, hit_now, take;
  logic                acc_vld;
  logic [COORD_W-1:0]  acc_y;
  logic [IDX_W-1:0]    acc_idx;
  logic [IDX_W:0]      acc_cnt;

  always_comb begin
    ox = '0;
    oy = '0;
    ov = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ox = xs_q[i*COORD_W +: COORD_W];
        oy = ys_q[i*COORD_W +: COORD_W];
        ov = vld_q[i];
      end
    end

    p_l  = W'(px_q);
    p_r  = W'(px_q) + W'(pw_q);
    o_l  = W'(ox);
    o_r  = W'(ox) + W'(ow_q);
    mw_s = W'(mw_q);
    // Part of the player that spills past the right edge reappears at x - map_width (may be negative).
    w_l  = p_l - mw_s;
    w_r  = p_r - mw_s;

    h_direct = (p_l < o_r) && (p_r > o_l);
    h_wrap   = (p_r > mw_s) && (w_l < o_r) && (w_r > o_l);

    feet     = W'(py_q) + W'(ph_q);
    feet_max = feet + W'(spd_q);
    oy_w     = W'(oy);
    v_ok     = (feet <= oy_w) && (oy_w <= feet_max);

    hit_now = ov && !fly_q && v_ok && (h_direct || h_wrap);

    // Strict '<' keeps the lower index on equal heights in nearest mode.
    take = hit_now && (!best_vld_q || ((NEAREST != 0) && (oy < best_y_q)));

    acc_vld = best_vld_q || hit_now;
    acc_y   = take ? oy : best_y_q;
    acc_idx = take ? idx_q : best_idx_q;
    acc_cnt = cnt_q + (IDX_W+1)'(hit_now);
  end

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    pw_d        = pw_q;
    ph_d        = ph_q;
    ow_d        = ow_q;
    mw_d        = mw_q;
    spd_d       = spd_q;
    fly_d       = fly_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    vld_d       = vld_q;
    idx_d       = idx_q;
    best_vld_d  = best_vld_q;
    best_y_d    = best_y_q;
    best_idx_d  = best_idx_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    floor_d     = floor_q;
    hit_idx_d   = hit_idx_q;
    hit_count_d = hit_count_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          px_d       = bus.plyr_x;
          py_d       = bus.plyr_y;
          pw_d       = bus.plyr_width;
          ph_d       = bus.plyr_height;
          ow_d       = bus.obj_width;
          mw_d       = bus.map_width;
          spd_d      = bus.spd_y;
          fly_d      = bus.fly;
          xs_d       = bus.obj_xs;
          ys_d       = bus.obj_ys;
          vld_d      = bus.obj_valid;
          idx_d      = '0;
          best_vld_d = 1'b0;
          best_y_d   = '0;
          best_idx_d = '0;
          cnt_d      = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        best_vld_d = acc_vld;
        best_y_d   = acc_y;
        best_idx_d = acc_idx;
        cnt_d      = acc_cnt;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_OBJ - 1)) begin
          // Results include the last platform evaluated this cycle.
          hit_d       = acc_vld;
          floor_d     = acc_vld ? acc_y : '0;
          hit_idx_d   = acc_vld ? acc_idx : '0;
          hit_count_d = acc_cnt;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      px_q        <= '0;
      py_q        <= '0;
      pw_q        <= '0;
      ph_q        <= '0;
      ow_q        <= '0;
      mw_q        <= '0;
      spd_q       <= '0;
      fly_q       <= 1'b0;
      xs_q        <= '0;
      ys_q        <= '0;
      vld_q       <= '0;
      idx_q       <= '0;
      best_vld_q  <= 1'b0;
      best_y_q    <= '0;
      best_idx_q  <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      floor_q     <= '0;
      hit_idx_q   <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pw_q        <= pw_d;
      ph_q        <= ph_d;
      ow_q        <= ow_d;
      mw_q        <= mw_d;
      spd_q       <= spd_d;
      fly_q       <= fly_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      vld_q       <= vld_d;
      idx_q       <= idx_d;
      best_vld_q  <= best_vld_d;
      best_y_q    <= best_y_d;
      best_idx_q  <= best_idx_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      floor_q     <= floor_d;
      hit_idx_q   <= hit_idx_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.floor     = floor_q;
  assign bus.hit_idx   = hit_idx_q;
  assign bus.hit_count = hit_count_q;
endmodule
